// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package div_unit_pkg;

  localparam int DIV_DATA_W   = 32;
  localparam int DIV_RESULT_W = 2 * DIV_DATA_W;

  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration on the {partial remainder, dividend/quotient} register.
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [2*DATA_W:0]   w_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W:0]   w_o
);

  logic [DATA_W+1:0] diff;

  // Trial window is the shifted partial remainder, one bit wider so the borrow is explicit.
  always_comb begin
    diff = w_i[2*DATA_W:DATA_W-1] - {2'b00, divisor_i};
    if (diff[DATA_W+1]) begin
      w_o = {w_i[2*DATA_W-1:0], 1'b0};
    end else begin
      w_o = {diff[DATA_W:0], w_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 signed/unsigned divider producing {remainder, quotient} for HI/LO.
//
// state      | meaning
// DIV_FREE   | idle, waiting for a start request
// DIV_BYZERO | divisor was zero; one cycle before reporting a zero result
// DIV_ON     | one restoring iteration per cycle, counter 0..ITER-1
// DIV_END    | result valid, held until start drops or annul
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int ITER   = DIV_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_dividend,
  input  logic [DATA_W-1:0]     i_divisor,
  input  logic                  i_annul,
  output logic [2*DATA_W-1:0]   o_result,
  output logic                  o_ready
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  div_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*DATA_W:0]      w_q;
  logic [2*DATA_W:0]      w_d;
  logic [DATA_W-1:0]      divisor_q;
  logic                   q_neg_q;
  logic                   r_neg_q;
  logic [2*DATA_W-1:0]    result_q;
  logic                   ready_q;

  logic [DATA_W-1:0]      dvd_abs;
  logic [DATA_W-1:0]      dvs_abs;
  logic [DATA_W-1:0]      q_fin;
  logic [DATA_W-1:0]      r_fin;

  always_comb begin
    dvd_abs = (i_signed && i_dividend[DATA_W-1]) ? (~i_dividend + 1'b1) : i_dividend;
    dvs_abs = (i_signed && i_divisor[DATA_W-1])  ? (~i_divisor + 1'b1)  : i_divisor;
  end

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .w_i       (w_q),
    .divisor_i (divisor_q),
    .w_o       (w_d)
  );

  // Sign correction taken from the final iteration so the result lands with the END transition.
  always_comb begin
    q_fin = q_neg_q ? (~w_d[DATA_W-1:0] + 1'b1) : w_d[DATA_W-1:0];
    r_fin = r_neg_q ? (~w_d[2*DATA_W-1:DATA_W] + 1'b1) : w_d[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      w_q       <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (i_start == DIV_START && !i_annul) begin
            if (i_divisor == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q   <= DIV_ON;
              cnt_q     <= '0;
              w_q       <= {{(DATA_W+1){1'b0}}, dvd_abs};
              divisor_q <= dvs_abs;
              q_neg_q   <= i_signed & (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
              r_neg_q   <= i_signed & i_dividend[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          if (i_annul) begin
            state_q <= DIV_FREE;
          end else begin
            state_q  <= DIV_END;
            result_q <= '0;
            ready_q  <= DIV_READY;
          end
        end
        DIV_ON: begin
          if (i_annul) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
          end else begin
            w_q <= w_d;
            if (cnt_q == CNT_LAST) begin
              state_q  <= DIV_END;
              cnt_q    <= '0;
              result_q <= {r_fin, q_fin};
              ready_q  <= DIV_READY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DIV_END: begin
          if (i_start == DIV_STOP || i_annul) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_NOT_READY;
          end
        end
        default: begin
          state_q <= DIV_FREE;
        end
      endcase
    end
  end

  assign o_result = result_q;
  assign o_ready  = ready_q;

endmodule
